// File: rtl/hqm_AW_sram_ctl_pkg.sv
// Shared types and default geometry for the 2048x139 SRAM controller.
package hqm_AW_sram_ctl_pkg;

    localparam int DEF_DEPTH  = 2048;
    localparam int DEF_AWIDTH = 11;
    localparam int DEF_DWIDTH = 139;

    // Controller power/init sequencing states
    typedef enum logic [2:0] {
        ST_OFF,
        ST_PWRUP,
        ST_ISOREL,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_PWRDN
    } state_t;

    // Requester identity carried with an in-flight read
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/hqm_AW_sram_ctl_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner.
module hqm_AW_sram_ctl_arb2
    import hqm_AW_sram_ctl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    port_t last_q, last_d;

    // Pick a winner: a lone requester wins, on conflict the one not granted last wins
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (enable) begin
            if (req[0] && (!req[1] || (last_q == PORT_B))) begin
                gnt    = 2'b01;
                last_d = PORT_A;
            end else if (req[1]) begin
                gnt    = 2'b10;
                last_d = PORT_B;
            end
        end
    end

    // Last-grant pointer; starts at B so A takes the first conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/hqm_aw_sram_2048x139_ctl.sv
// Power sequencing, zero-init and two-port access control for the SRAM macro.
module hqm_aw_sram_2048x139_ctl
    import hqm_AW_sram_ctl_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] a_rdata,
    output logic [DWIDTH-1:0] b_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              mem_pwr_enable_b,
    input  logic              mem_pwr_enable_b_ack,
    output logic              mem_isol_en,
    input  logic              pwr_down_req,
    output logic              init_done,
    output logic              busy
);

    // Init counter is one bit wider than the address
    localparam int CW = AWIDTH + 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tag_vld_q, tag_vld_d;
    port_t             tag_q, tag_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DWIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DWIDTH-1:0] b_rdata_q, b_rdata_d;
    logic              arb_en;
    logic [1:0]        gnt;
    logic              init_last;

    // Grants only in RUN, and stop in the very cycle a power-down is requested
    assign arb_en = (state_q == ST_RUN) && !pwr_down_req && !rst;

    hqm_AW_sram_ctl_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({b_req, a_req}),
        .enable (arb_en),
        .gnt    (gnt)
    );

    assign a_gnt     = gnt[0];
    assign b_gnt     = gnt[1];
    assign init_last = (cnt_q == CW'(DEPTH - 1));

    // Next-state sequencing and init address counting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF:    if (!pwr_down_req) state_d = ST_PWRUP;
            ST_PWRUP:  if (!mem_pwr_enable_b_ack) state_d = ST_ISOREL;
            ST_ISOREL: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
            ST_INIT: begin
                cnt_d = cnt_q + CW'(1);
                if (init_last) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN:    if (pwr_down_req) state_d = ST_DRAIN;
            ST_DRAIN:  if (!tag_vld_q) state_d = ST_PWRDN;
            ST_PWRDN:  if (mem_pwr_enable_b_ack) state_d = ST_OFF;
            default:   state_d = ST_OFF;
        endcase
    end

    // Macro-facing controls: power/isolation by state, access from init or the winner
    always_comb begin
        mem_pwr_enable_b = 1'b0;
        mem_isol_en      = 1'b0;
        mem_re           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (state_q)
            ST_OFF, ST_PWRDN: begin
                mem_pwr_enable_b = 1'b1;
                mem_isol_en      = 1'b1;
            end
            ST_PWRUP: mem_isol_en = 1'b1;
            ST_INIT: begin
                if (!rst) begin
                    mem_we   = 1'b1;
                    mem_addr = cnt_q[AWIDTH-1:0];
                end
            end
            ST_RUN: begin
                if (gnt[0]) begin
                    mem_we    = a_we;
                    mem_re    = !a_we;
                    mem_addr  = a_addr;
                    mem_wdata = a_wdata;
                end else if (gnt[1]) begin
                    mem_we    = b_we;
                    mem_re    = !b_we;
                    mem_addr  = b_addr;
                    mem_wdata = b_wdata;
                end
            end
            ST_ISOREL, ST_DRAIN: ;
            default: begin
                mem_pwr_enable_b = 1'b1;
                mem_isol_en      = 1'b1;
            end
        endcase
    end

    // Read tag pipe and response steering; rdata holds between reads
    always_comb begin
        tag_vld_d  = mem_re;
        tag_d      = gnt[1] ? PORT_B : PORT_A;
        a_rvalid_d = tag_vld_q && (tag_q == PORT_A);
        b_rvalid_d = tag_vld_q && (tag_q == PORT_B);
        a_rdata_d  = a_rvalid_d ? mem_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? mem_rdata : b_rdata_q;
    end

    // State, counter, tag and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            tag_vld_q  <= 1'b0;
            tag_q      <= PORT_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_q      <= tag_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign init_done = (state_q == ST_RUN);
    assign busy      = (state_q != ST_RUN) && (state_q != ST_OFF);

endmodule

// File: tb/tb_hqm_aw_sram_2048x139_ctl.sv
// Bench for the SRAM controller: SRAM + power-chain model, vector table,
// random traffic against a memory/round-robin scoreboard, power and reset sequences.
module tb_hqm_aw_sram_2048x139_ctl;

    localparam int DP = 2048;
    localparam int AW = 11;
    localparam int DW = 139;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_pwr_enable_b, mem_isol_en;
    logic          mem_pwr_enable_b_ack;
    logic          pwr_down_req;
    logic          init_done, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    hqm_aw_sram_2048x139_ctl dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_pwr_enable_b(mem_pwr_enable_b),
        .mem_pwr_enable_b_ack(mem_pwr_enable_b_ack),
        .mem_isol_en(mem_isol_en),
        .pwr_down_req(pwr_down_req),
        .init_done(init_done), .busy(busy)
    );

    function automatic logic [DW-1:0] rand_word();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SRAM macro model: registered read, power chain ack 3 cycles behind enable,
    // contents scrambled whenever power is removed
    logic [DW-1:0] sram [DP];
    logic [2:0]    ack_pipe   = 3'b111;
    logic          pwr_b_prev = 1'b1;
    assign mem_pwr_enable_b_ack = ack_pipe[2];

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        ack_pipe   <= {ack_pipe[1:0], mem_pwr_enable_b};
        pwr_b_prev <= mem_pwr_enable_b;
        if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr];
        if (mem_pwr_enable_b && !pwr_b_prev)
            for (int i = 0; i < DP; i++) sram[i] <= rand_word();
    end

    // Reference model: expected memory contents, pending read responses,
    // and which port was granted most recently
    typedef struct {
        int            due;
        bit            port;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rq[$];
    logic [DW-1:0] shadow [DP];
    bit            run_mode = 1'b0;
    bit            last_b   = 1'b1;

    always @(negedge clk) begin : sb
        bit            ea, eb, ga, gb, we;
        logic [DW-1:0] da, db, wd;
        logic [AW-1:0] ad;
        ea = 1'b0; eb = 1'b0; da = '0; db = '0;
        foreach (rq[i]) begin
            if (rq[i].due == cyc) begin
                if (rq[i].port) begin eb = 1'b1; db = rq[i].data; end
                else            begin ea = 1'b1; da = rq[i].data; end
            end
        end
        while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        if (ea || a_rvalid)
            chk(a_rvalid == ea && (!ea || a_rdata == da), "rsp_a", 160'({a_rvalid, a_rdata}), 160'({ea, da}));
        if (eb || b_rvalid)
            chk(b_rvalid == eb && (!eb || b_rdata == db), "rsp_b", 160'({b_rvalid, b_rdata}), 160'({eb, db}));
        if (mem_re && mem_we)
            chk(1'b0, "re_we_both", 160'({mem_re, mem_we}), 160'(0));
        if (rst) begin
            rq.delete();
            last_b = 1'b1;
        end else if (run_mode) begin
            ga = a_req && !pwr_down_req && (!b_req || last_b);
            gb = b_req && !pwr_down_req && !ga;
            if (a_req || b_req)
                chk({a_gnt, b_gnt} == {ga, gb}, "rr_gnt", 160'({a_gnt, b_gnt}), 160'({ga, gb}));
            if (ga || gb) begin
                we = ga ? a_we : b_we;
                ad = ga ? a_addr : b_addr;
                wd = ga ? a_wdata : b_wdata;
                chk(mem_we == we && mem_re == !we && mem_addr == ad && (!we || mem_wdata == wd),
                    "mem_drive", 160'({mem_we, mem_re, mem_addr}), 160'({we, !we, ad}));
                if (we) shadow[ad] = wd;
                else rq.push_back('{due: cyc + 2, port: gb, data: shadow[ad]});
                last_b = gb;
            end
        end else if (a_gnt || b_gnt) begin
            chk(1'b0, "gnt_outside_run", 160'({a_gnt, b_gnt}), 160'(0));
        end
    end

    task automatic check_reset_vals(input string nm);
        logic [15:0] act;
        act = {mem_pwr_enable_b, mem_isol_en, mem_re, mem_we, |mem_addr, |mem_wdata,
               a_gnt, b_gnt, a_rvalid, b_rvalid, |a_rdata, |b_rdata, init_done, busy, 2'b00};
        chk(act == 16'hC000, nm, 160'(act), 160'(16'hC000));
    endtask

    // Bring the macro up from OFF and check the full zero-init sweep.
    // stop_at >= 0 asserts reset while that init address is on the bus.
    task automatic power_up_init(input int stop_at);
        int n;
        int errs;
        for (int i = 0; i < DP; i++) shadow[i] = '0;
        run_mode     = 1'b0;
        pwr_down_req = 1'b0;
        n = 0;
        while (mem_pwr_enable_b && n < 20) begin tick(); n++; end
        chk(n < 20 && mem_isol_en, "pwrup", 160'({mem_pwr_enable_b, mem_isol_en}), 160'(2'b01));
        n = 0;
        while (mem_isol_en && n < 20) begin tick(); n++; end
        chk(n < 20 && !mem_pwr_enable_b_ack && !mem_we && busy, "isorel",
            160'({mem_isol_en, mem_pwr_enable_b_ack, mem_we, busy}), 160'(4'b0001));
        tick();
        a_req = 1'b1; a_we = 1'b0; a_addr = '0; b_req = 1'b0;
        errs = 0;
        for (int i = 0; i < DP; i++) begin
            if (!(mem_we && !mem_re && mem_addr == AW'(i) && mem_wdata == '0 &&
                  !init_done && busy && !a_gnt && !b_gnt)) errs++;
            if (i == stop_at) begin
                a_req = 1'b0;
                rst   = 1'b1;
                tick();
                chk(errs == 0, "init_prefix", 160'(errs), 160'(0));
                check_reset_vals("rst_mid_init");
                repeat (5) tick();
                rst = 1'b0;
                return;
            end
            if (i == DP - 1) a_req = 1'b0;
            tick();
        end
        chk(errs == 0, "init_seq", 160'(errs), 160'(0));
        chk(init_done && !busy, "init_done", 160'({init_done, busy}), 160'(2'b10));
        run_mode = 1'b1;
    endtask

    typedef struct {
        bit            ar, aw;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        bit            br, bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        bit            ega, egb;
    } vec_t;

    function automatic vec_t mk(bit ar, bit aw, logic [AW-1:0] aa, logic [DW-1:0] ad,
                                bit br, bit bw, logic [AW-1:0] ba, logic [DW-1:0] bd,
                                bit ega, bit egb);
        vec_t v;
        v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
        v.ega = ega; v.egb = egb;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [143:0]  rep;
        logic [DW-1:0] pat, p2, p3;
        rep = {18{8'h5A}};
        pat = rep[DW-1:0];
        p2  = rand_word();
        p3  = rand_word();
        for (int i = 0; i < DP; i++) sram[i] = rand_word();

        rst = 1'b1; pwr_down_req = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) tick();
        check_reset_vals("reset_vals");
        rst = 1'b0;
        power_up_init(-1);

        // Directed vectors: grants follow round robin from a B-pointer start
        tbl[0] = mk(1, 0, 11'h7FF, '0, 0, 0, '0, '0, 1, 0);
        tbl[1] = mk(0, 0, '0, '0, 1, 1, 11'h123, pat, 0, 1);
        tbl[2] = mk(1, 0, 11'h123, '0, 0, 0, '0, '0, 1, 0);
        tbl[3] = mk(0, 0, '0, '0, 1, 0, 11'h010, '0, 0, 1);
        for (int k = 0; k < 6; k++)
            tbl[4 + k] = mk(1, 0, 11'h123, '0, 1, 0, 11'h7FF, '0, (k % 2) == 0, (k % 2) == 1);
        tbl[10] = mk(0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
        tbl[11] = mk(1, 1, 11'h200, p2, 1, 1, 11'h201, p3, 1, 0);
        tbl[12] = mk(1, 0, 11'h200, '0, 1, 0, 11'h201, '0, 0, 1);
        tbl[13] = mk(0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
        foreach (tbl[i]) begin
            a_req = tbl[i].ar; a_we = tbl[i].aw; a_addr = tbl[i].aa; a_wdata = tbl[i].ad;
            b_req = tbl[i].br; b_we = tbl[i].bw; b_addr = tbl[i].ba; b_wdata = tbl[i].bd;
            #1;
            chk({a_gnt, b_gnt} == {tbl[i].ega, tbl[i].egb}, "tbl_gnt",
                160'({a_gnt, b_gnt}), 160'({tbl[i].ega, tbl[i].egb}));
            tick();
        end
        repeat (3) tick();

        // Random traffic on a small address set to force read-after-write hits
        for (int i = 0; i < 400; i++) begin
            a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
            b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
            a_addr = ($urandom_range(0, 7) == 0) ? 11'h7FF : AW'($urandom_range(0, 15));
            b_addr = ($urandom_range(0, 7) == 0) ? 11'h7FF : AW'($urandom_range(0, 15));
            a_wdata = rand_word(); b_wdata = rand_word();
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) tick();

        // Power-down right behind a granted read: the read still completes
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'h123;
        #1 chk(a_gnt, "pd_grant", 160'(a_gnt), 160'(1));
        tick();
        a_req = 1'b0; pwr_down_req = 1'b1; run_mode = 1'b0;
        #1 chk(!a_gnt && !b_gnt && init_done, "pd_nogrant", 160'({a_gnt, b_gnt, init_done}), 160'(3'b001));
        tick();
        chk(busy && !mem_isol_en && !mem_pwr_enable_b && !init_done, "drain",
            160'({busy, mem_isol_en, mem_pwr_enable_b, init_done}), 160'(4'b1000));
        tick();
        chk(busy && mem_isol_en && mem_pwr_enable_b, "pwrdn",
            160'({busy, mem_isol_en, mem_pwr_enable_b}), 160'(3'b111));
        begin
            int n;
            n = 0;
            while (busy && n < 20) begin tick(); n++; end
            chk(n < 20 && mem_pwr_enable_b_ack && mem_pwr_enable_b && mem_isol_en && !init_done, "off",
                160'({mem_pwr_enable_b_ack, mem_pwr_enable_b, mem_isol_en, init_done}), 160'(4'b1110));
        end
        repeat (4) tick();
        power_up_init(-1);

        // Data is gone after the power cycle
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'h123;
        tick();
        a_req = 1'b0;
        tick();
        chk(a_rvalid && a_rdata == '0, "post_pd_read", 160'({a_rvalid, a_rdata}), 160'({1'b1, {DW{1'b0}}}));
        tick();

        // Reset during a read: the response is dropped
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'h7FF;
        #1 chk(a_gnt, "rstrd_grant", 160'(a_gnt), 160'(1));
        tick();
        a_req = 1'b0; rst = 1'b1; run_mode = 1'b0;
        tick();
        chk(!a_rvalid && !b_rvalid && a_rdata == '0, "rst_drops_rvalid",
            160'({a_rvalid, b_rvalid, a_rdata}), 160'(0));
        check_reset_vals("rst_after_read");
        repeat (5) tick();
        rst = 1'b0;

        // Reset mid-INIT, then a clean restart from address 0
        power_up_init(12'h400);
        power_up_init(-1);
        b_req = 1'b1; b_we = 1'b0; b_addr = 11'h400;
        tick();
        b_req = 1'b0;
        tick();
        chk(b_rvalid && b_rdata == '0 && !a_rvalid, "final_read",
            160'({b_rvalid, a_rvalid, b_rdata}), 160'({2'b10, {DW{1'b0}}}));
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
